// File: rtl/decode_mul_arb_pkg.sv
// Shared widths, id-width helper and pipeline tag type for the shared decode multiplier.
package decode_mul_arb_pkg;

    localparam int unsigned DEF_A_WIDTH = 40;
    localparam int unsigned DEF_B_WIDTH = 32;
    localparam int unsigned DEF_P_WIDTH = 70;

    // Wide enough for the largest supported requester count (8).
    localparam int unsigned TAG_ID_W = 3;

    function automatic int unsigned id_w(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    typedef struct packed {
        logic                valid;
        logic [TAG_ID_W-1:0] id;
    } pipe_tag_t;

endpackage

// File: rtl/decode_rr_arbiter.sv
// Round-robin arbiter: first active request at or after rr_ptr, wrapping modulo NUM_REQ.
module decode_rr_arbiter
    import decode_mul_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    localparam int unsigned ID_W = id_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    rr_ptr,
    input  logic               adv,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    grant_id,
    output logic               any_grant
);

    logic            found;
    logic [ID_W-1:0] sel;
    int unsigned     idx;

    always_comb begin
        found = 1'b0;
        sel   = '0;
        idx   = 0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            idx = (k + 32'(rr_ptr)) % NUM_REQ;
            if (!found && req[idx]) begin
                found = 1'b1;
                sel   = idx[ID_W-1:0];
            end
        end
    end

    // grant_id stays valid without adv so it can steer the operand mux unconditionally.
    assign grant_id  = sel;
    assign any_grant = adv & found;

    always_comb begin
        grant = '0;
        if (any_grant) grant[sel] = 1'b1;
    end

endmodule

// File: rtl/decode_mul_share_arb.sv
// Shared signed x unsigned pipelined multiplier with round-robin requester arbitration.
// Optional statistics counters via DECODE_MUL_SHARE_ARB_STATS_EN.
module decode_mul_share_arb
    import decode_mul_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned A_WIDTH = DEF_A_WIDTH,
    parameter int unsigned B_WIDTH = DEF_B_WIDTH,
    parameter int unsigned P_WIDTH = DEF_P_WIDTH,
    parameter int unsigned MUL_LAT = 1,
    localparam int unsigned ID_W = id_w(NUM_REQ)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       ce,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [NUM_REQ*A_WIDTH-1:0] req_a,
    input  logic [NUM_REQ*B_WIDTH-1:0] req_b,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [ID_W-1:0]            rsp_id,
    output logic [P_WIDTH-1:0]         rsp_data
`ifdef DECODE_MUL_SHARE_ARB_STATS_EN
    ,
    output logic [31:0]                stat_issue_cnt,
    output logic [31:0]                stat_stall_cnt
`endif
);

    logic                      adv;
    logic [ID_W-1:0]           rr_ptr;
    logic [ID_W-1:0]           grant_id;
    logic [NUM_REQ-1:0]        grant;
    logic                      any_grant;
    logic signed [A_WIDTH-1:0] a_sel;
    logic signed [B_WIDTH:0]   b_sel;
    logic signed [P_WIDTH-1:0] prod;
    pipe_tag_t                 tag_q  [MUL_LAT];
    logic [P_WIDTH-1:0]        data_q [MUL_LAT];
    logic                      unused_tag_bits;

    // A pending response the consumer refuses freezes the entire pipeline.
    assign adv = ce & ~(rsp_valid & ~rsp_ready);

    decode_rr_arbiter #(
        .NUM_REQ(NUM_REQ)
    ) u_arb (
        .req      (req_valid),
        .rr_ptr   (rr_ptr),
        .adv      (adv),
        .grant    (grant),
        .grant_id (grant_id),
        .any_grant(any_grant)
    );

    assign req_ready = grant;

    always_comb begin
        a_sel = req_a[32'(grant_id)*A_WIDTH +: A_WIDTH];
        b_sel = {1'b0, req_b[32'(grant_id)*B_WIDTH +: B_WIDTH]};
        prod  = P_WIDTH'(a_sel) * P_WIDTH'(b_sel);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr <= '0;
        end else if (any_grant) begin
            rr_ptr <= (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + ID_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned s = 0; s < MUL_LAT; s++) tag_q[s] <= '0;
        end else if (adv) begin
            tag_q[0].valid <= any_grant;
            tag_q[0].id    <= TAG_ID_W'(grant_id);
            for (int unsigned s = 1; s < MUL_LAT; s++) tag_q[s] <= tag_q[s-1];
        end
    end

    always_ff @(posedge clk) begin
        if (adv) begin
            data_q[0] <= prod;
            for (int unsigned s = 1; s < MUL_LAT; s++) data_q[s] <= data_q[s-1];
        end
    end

    assign rsp_valid       = tag_q[MUL_LAT-1].valid;
    assign rsp_id          = tag_q[MUL_LAT-1].id[ID_W-1:0];
    assign rsp_data        = data_q[MUL_LAT-1];
    assign unused_tag_bits = ^tag_q[MUL_LAT-1].id;

`ifdef DECODE_MUL_SHARE_ARB_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            stat_issue_cnt <= '0;
            stat_stall_cnt <= '0;
        end else begin
            if (any_grant && stat_issue_cnt != '1)
                stat_issue_cnt <= stat_issue_cnt + 32'd1;
            if (ce && rsp_valid && !rsp_ready && stat_stall_cnt != '1)
                stat_stall_cnt <= stat_stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_decode_mul_share_arb.sv
// Directed, table-driven bench for decode_mul_share_arb (NUM_REQ=4, MUL_LAT=1).
module tb_decode_mul_share_arb;

    localparam int unsigned NUM_REQ = 4;
    localparam int unsigned A_WIDTH = 40;
    localparam int unsigned B_WIDTH = 32;
    localparam int unsigned P_WIDTH = 70;

    logic                       clk = 1'b0;
    logic                       reset;
    logic                       ce;
    logic [NUM_REQ-1:0]         req_valid;
    logic [NUM_REQ-1:0]         req_ready;
    logic [NUM_REQ*A_WIDTH-1:0] req_a;
    logic [NUM_REQ*B_WIDTH-1:0] req_b;
    logic                       rsp_valid;
    logic                       rsp_ready;
    logic [1:0]                 rsp_id;
    logic [P_WIDTH-1:0]         rsp_data;
`ifdef DECODE_MUL_SHARE_ARB_STATS_EN
    logic [31:0]                stat_issue_cnt;
    logic [31:0]                stat_stall_cnt;
`endif

    decode_mul_share_arb #(
        .NUM_REQ(NUM_REQ),
        .A_WIDTH(A_WIDTH),
        .B_WIDTH(B_WIDTH),
        .P_WIDTH(P_WIDTH),
        .MUL_LAT(1)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .ce       (ce),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_a    (req_a),
        .req_b    (req_b),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_id   (rsp_id),
        .rsp_data (rsp_data)
`ifdef DECODE_MUL_SHARE_ARB_STATS_EN
        ,
        .stat_issue_cnt(stat_issue_cnt),
        .stat_stall_cnt(stat_stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       rst;
        logic       ce;
        logic [3:0] vld;
        logic       rdy;
        logic [3:0] exp_ready;
        logic       exp_rv;
        logic [1:0] exp_id;
    } vec_t;

    vec_t                      tbl[$];
    int unsigned               n_chk  = 0;
    int unsigned               n_fail = 0;
    logic signed [A_WIDTH-1:0] op_a [NUM_REQ];
    logic [B_WIDTH-1:0]        op_b [NUM_REQ];
    logic [P_WIDTH-1:0]        exp_const;

    function automatic vec_t mk(input logic rst, input logic c, input logic [3:0] v,
                                input logic r, input logic [3:0] er, input logic erv,
                                input logic [1:0] eid);
        vec_t t;
        t = '{rst: rst, ce: c, vld: v, rdy: r, exp_ready: er, exp_rv: erv, exp_id: eid};
        return t;
    endfunction

    // Reference product computed at 80 bits, then reduced to the product width.
    function automatic logic [P_WIDTH-1:0] expect_prod(input int unsigned id);
        logic signed [79:0] x;
        logic signed [79:0] y;
        logic signed [79:0] p;
        x = 80'(op_a[id]);
        y = 80'(op_b[id]);
        p = x * y;
        return p[P_WIDTH-1:0];
    endfunction

    task automatic check(input string name, input logic [P_WIDTH-1:0] act,
                         input logic [P_WIDTH-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    initial begin
        op_a[0] = -40'sd3;             op_b[0] = 32'hFFFF_FFFF;
        op_a[1] = 40'sd5;              op_b[1] = 32'd7;
        op_a[2] = 40'sh80_0000_0000;   op_b[2] = 32'hFFFF_FFFF;
        op_a[3] = 40'sh7F_FFFF_FFFF;   op_b[3] = 32'h8000_0000;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_a[i*A_WIDTH +: A_WIDTH] = op_a[i];
            req_b[i*B_WIDTH +: B_WIDTH] = op_b[i];
        end
        exp_const = -70'sd12884901885;

        // single request, then reset back to rr_ptr=0
        tbl.push_back(mk(0, 1, 4'b0001, 1, 4'b0001, 0, 0));
        tbl.push_back(mk(0, 1, 4'b0000, 1, 4'b0000, 1, 0));
        tbl.push_back(mk(1, 1, 4'b0000, 1, 4'b0000, 0, 0));
        // all four requesting: 0,1,2,3,0,1,2,3 back to back
        tbl.push_back(mk(0, 1, 4'b1111, 1, 4'b0001, 0, 0));
        tbl.push_back(mk(0, 1, 4'b1111, 1, 4'b0010, 1, 0));
        tbl.push_back(mk(0, 1, 4'b1111, 1, 4'b0100, 1, 1));
        tbl.push_back(mk(0, 1, 4'b1111, 1, 4'b1000, 1, 2));
        tbl.push_back(mk(0, 1, 4'b1111, 1, 4'b0001, 1, 3));
        tbl.push_back(mk(0, 1, 4'b1111, 1, 4'b0010, 1, 0));
        tbl.push_back(mk(0, 1, 4'b1111, 1, 4'b0100, 1, 1));
        tbl.push_back(mk(0, 1, 4'b1111, 1, 4'b1000, 1, 2));
        tbl.push_back(mk(0, 1, 4'b0000, 1, 4'b0000, 1, 3));
        tbl.push_back(mk(0, 1, 4'b0000, 1, 4'b0000, 0, 0));
        // move rr_ptr to 2, then requesters 1 and 3 contend
        tbl.push_back(mk(0, 1, 4'b0010, 1, 4'b0010, 0, 0));
        tbl.push_back(mk(0, 1, 4'b1010, 1, 4'b1000, 1, 1));
        tbl.push_back(mk(0, 1, 4'b1010, 1, 4'b0010, 1, 3));
        tbl.push_back(mk(0, 1, 4'b1000, 1, 4'b1000, 1, 1));
        tbl.push_back(mk(0, 1, 4'b0000, 1, 4'b0000, 1, 3));
        tbl.push_back(mk(0, 1, 4'b0000, 1, 4'b0000, 0, 0));
        // backpressure for three cycles with all requesters active
        tbl.push_back(mk(0, 1, 4'b1111, 1, 4'b0001, 0, 0));
        tbl.push_back(mk(0, 1, 4'b1111, 0, 4'b0000, 1, 0));
        tbl.push_back(mk(0, 1, 4'b1111, 0, 4'b0000, 1, 0));
        tbl.push_back(mk(0, 1, 4'b1111, 0, 4'b0000, 1, 0));
        tbl.push_back(mk(0, 1, 4'b1111, 1, 4'b0010, 1, 0));
        tbl.push_back(mk(0, 1, 4'b1111, 1, 4'b0100, 1, 1));
        tbl.push_back(mk(0, 1, 4'b1111, 1, 4'b1000, 1, 2));
        tbl.push_back(mk(0, 1, 4'b0000, 1, 4'b0000, 1, 3));
        tbl.push_back(mk(0, 1, 4'b0000, 1, 4'b0000, 0, 0));
        // ce low for two cycles mid-stream
        tbl.push_back(mk(0, 1, 4'b1111, 1, 4'b0001, 0, 0));
        tbl.push_back(mk(0, 0, 4'b1111, 1, 4'b0000, 1, 0));
        tbl.push_back(mk(0, 0, 4'b1111, 1, 4'b0000, 1, 0));
        tbl.push_back(mk(0, 1, 4'b1111, 1, 4'b0010, 1, 0));
        tbl.push_back(mk(0, 1, 4'b0100, 1, 4'b0100, 1, 1));
        // reset with requester 2's op in flight: dropped, pointer back to 0
        tbl.push_back(mk(1, 1, 4'b0000, 1, 4'b0000, 1, 2));
        tbl.push_back(mk(0, 1, 4'b0000, 1, 4'b0000, 0, 0));
        tbl.push_back(mk(0, 1, 4'b1111, 1, 4'b0001, 0, 0));
        tbl.push_back(mk(0, 1, 4'b0000, 1, 4'b0000, 1, 0));
        tbl.push_back(mk(0, 1, 4'b0000, 1, 4'b0000, 0, 0));

        reset = 1'b1; ce = 1'b1; req_valid = '0; rsp_ready = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        check("reset rsp_valid", 70'(rsp_valid), 70'(1'b0));
        check("reset rsp_id",    70'(rsp_id),    70'(2'd0));
        check("reset req_ready", 70'(req_ready), 70'(4'b0000));

        foreach (tbl[i]) begin
            @(negedge clk);
            reset     = tbl[i].rst;
            ce        = tbl[i].ce;
            req_valid = tbl[i].vld;
            rsp_ready = tbl[i].rdy;
            #1;
            check($sformatf("row%0d req_ready", i), 70'(req_ready), 70'(tbl[i].exp_ready));
            check($sformatf("row%0d rsp_valid", i), 70'(rsp_valid), 70'(tbl[i].exp_rv));
            if (tbl[i].exp_rv) begin
                check($sformatf("row%0d rsp_id", i), 70'(rsp_id), 70'(tbl[i].exp_id));
                check($sformatf("row%0d rsp_data", i), rsp_data, expect_prod(32'(tbl[i].exp_id)));
            end
        end

        // -3 x 0xFFFFFFFF against a hand-computed constant
        @(negedge clk); reset = 1'b1; ce = 1'b1; req_valid = '0; rsp_ready = 1'b1;
        @(negedge clk); reset = 1'b0; req_valid = 4'b0001;
        @(negedge clk); req_valid = '0;
        #1;
        check("t1 rsp_valid", 70'(rsp_valid), 70'(1'b1));
        check("t1 rsp_id",    70'(rsp_id),    70'(2'd0));
        check("t1 rsp_data",  rsp_data,       exp_const);

        // ten transfers followed by three stall cycles
        @(negedge clk); reset = 1'b1; req_valid = '0;
        @(negedge clk); reset = 1'b0; req_valid = 4'b0001;
        repeat (9) @(negedge clk);
        @(negedge clk); req_valid = '0; rsp_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            check($sformatf("stall%0d rsp_valid", k), 70'(rsp_valid), 70'(1'b1));
            check($sformatf("stall%0d rsp_data", k),  rsp_data,       expect_prod(0));
            check($sformatf("stall%0d req_ready", k), 70'(req_ready), 70'(4'b0000));
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        #1;
        check("drain rsp_valid", 70'(rsp_valid), 70'(1'b1));
        @(negedge clk);
        #1;
        check("after drain rsp_valid", 70'(rsp_valid), 70'(1'b0));
`ifdef DECODE_MUL_SHARE_ARB_STATS_EN
        check("stat_issue_cnt", 70'(stat_issue_cnt), 70'(32'd10));
        check("stat_stall_cnt", 70'(stat_stall_cnt), 70'(32'd3));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
